// File: rtl/hazard_stall_unit.sv
// Hazard detection and pipeline-freeze controller beside the ID stage.
// Stalls when forwarding cannot supply an operand; freezes all stages during multi-cycle SRAM accesses.
module hazard_stall_unit #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forward_en,
   input  logic [4:0]       ID_src1,
   input  logic [4:0]       ID_src2,
   input  logic             ID_Is_Imm,
   input  logic             ID_MEM_W_En,
   input  logic [1:0]       ID_BR_Type,
   input  logic [4:0]       EXE_dest,
   input  logic             EXE_WB_En,
   input  logic             EXE_MEM_R_En,
   input  logic [4:0]       MEM_dest,
   input  logic             MEM_WB_En,
   input  logic             mem_start,
   input  logic             sram_ready,
   output logic             stall_if_id,
   output logic             bubble_exe,
   output logic             freeze_all,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t          state, stateNext;
   logic [TW-1:0]   timer, timerNext;
   logic            setError;
   logic            freezeRaw;
   logic            src1Used, src2Used;
   logic            exeHit, memHit, hazard;

   always_comb begin
      src1Used = (ID_BR_Type != 2'b11);
      src2Used = ~ID_Is_Imm | ID_MEM_W_En | (ID_BR_Type == 2'b10);
      exeHit   = EXE_WB_En && (EXE_dest != 5'd0) &&
                 ((src1Used && (ID_src1 == EXE_dest)) || (src2Used && (ID_src2 == EXE_dest)));
      memHit   = MEM_WB_En && (MEM_dest != 5'd0) &&
                 ((src1Used && (ID_src1 == MEM_dest)) || (src2Used && (ID_src2 == MEM_dest)));
      hazard   = forward_en ? (exeHit && EXE_MEM_R_En) : (exeHit || memHit);
   end

   always_comb begin
      stateNext = state;
      timerNext = timer;
      setError  = 1'b0;
      freezeRaw = 1'b0;
      case (state)
         RUN: begin
            if (mem_start && !sram_ready) begin
               stateNext = MEM_WAIT;
               timerNext = '0;
               freezeRaw = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (sram_ready) begin
               stateNext = RUN;
            end else begin
               freezeRaw = 1'b1;
               if (timer == TIMER_LAST) begin
                  stateNext = RUN;
                  setError  = 1'b1;
               end else begin
                  timerNext = timer + TW'(1);
               end
            end
         end
         default: stateNext = RUN;
      endcase
   end

   // Reset masks the combinational controls so no stall or freeze leaks out while rst is held.
   always_comb begin
      freeze_all  = freezeRaw & ~rst;
      stall_if_id = hazard & ~freezeRaw & ~rst;
      bubble_exe  = stall_if_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         timer      <= '0;
         mem_error  <= 1'b0;
         stall_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         state <= stateNext;
         timer <= timerNext;
         if (setError)
            mem_error <= 1'b1;
         if (stall_if_id && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (freeze_all && (freeze_cnt != '1))
            freeze_cnt <= freeze_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, directed multi-cycle sequences,
// and randomized traffic compared against a rule-level reference model.
module tb_hazard_stall_unit;

   localparam int MT   = 8;
   localparam int CW   = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          forward_en;
   logic [4:0]    ID_src1, ID_src2;
   logic          ID_Is_Imm, ID_MEM_W_En;
   logic [1:0]    ID_BR_Type;
   logic [4:0]    EXE_dest;
   logic          EXE_WB_En, EXE_MEM_R_En;
   logic [4:0]    MEM_dest;
   logic          MEM_WB_En;
   logic          mem_start, sram_ready;
   logic          stall_if_id, bubble_exe, freeze_all, mem_error;
   logic [CW-1:0] stall_cnt, freeze_cnt;

   int nTests = 0;
   int nFail  = 0;

   // reference model state
   bit mInWait;
   int mWaited;
   bit mErr;
   int mStall;
   int mFreeze;

   hazard_stall_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .forward_en(forward_en),
      .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_Is_Imm(ID_Is_Imm),
      .ID_MEM_W_En(ID_MEM_W_En), .ID_BR_Type(ID_BR_Type),
      .EXE_dest(EXE_dest), .EXE_WB_En(EXE_WB_En), .EXE_MEM_R_En(EXE_MEM_R_En),
      .MEM_dest(MEM_dest), .MEM_WB_En(MEM_WB_En),
      .mem_start(mem_start), .sram_ready(sram_ready),
      .stall_if_id(stall_if_id), .bubble_exe(bubble_exe), .freeze_all(freeze_all),
      .mem_error(mem_error), .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       fe;
      bit [4:0] s1, s2;
      bit       imm, memw;
      bit [1:0] br;
      bit [4:0] ed;
      bit       ewb, eld;
      bit [4:0] md;
      bit       mwb;
      bit       expStall;
   } vec_t;

   function automatic vec_t mk(int fe, int s1, int s2, int imm, int memw, int br,
                               int ed, int ewb, int eld, int md, int mwb, int ex);
      vec_t v;
      v.fe = fe[0]; v.s1 = 5'(s1); v.s2 = 5'(s2); v.imm = imm[0]; v.memw = memw[0];
      v.br = 2'(br); v.ed = 5'(ed); v.ewb = ewb[0]; v.eld = eld[0];
      v.md = 5'(md); v.mwb = mwb[0]; v.expStall = ex[0];
      return v;
   endfunction

   task automatic setVec(input vec_t v);
      forward_en = v.fe; ID_src1 = v.s1; ID_src2 = v.s2; ID_Is_Imm = v.imm;
      ID_MEM_W_En = v.memw; ID_BR_Type = v.br; EXE_dest = v.ed; EXE_WB_En = v.ewb;
      EXE_MEM_R_En = v.eld; MEM_dest = v.md; MEM_WB_En = v.mwb;
   endtask

   task automatic clearHazardInputs();
      setVec(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Hazard from the operand/producer rules: collect used sources, collect producers that
   // forwarding cannot cover, and look for any common register.
   function automatic bit refHazard();
      int used[$];
      int prod[$];
      if (ID_BR_Type != 2'b11) used.push_back(int'(ID_src1));
      if (!ID_Is_Imm || ID_MEM_W_En || ID_BR_Type == 2'b10) used.push_back(int'(ID_src2));
      if (EXE_WB_En && EXE_dest != 0 && (!forward_en || EXE_MEM_R_En)) prod.push_back(int'(EXE_dest));
      if (!forward_en && MEM_WB_En && MEM_dest != 0) prod.push_back(int'(MEM_dest));
      foreach (used[i])
         foreach (prod[j])
            if (used[i] == prod[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit refFreeze();
      if (rst) return 1'b0;
      return mInWait ? !sram_ready : (mem_start && !sram_ready);
   endfunction

   task automatic modelReset();
      mInWait = 0; mWaited = 0; mErr = 0; mStall = 0; mFreeze = 0;
   endtask

   task automatic sampleCheck();
      bit f, s;
      @(negedge clk);
      f = refFreeze();
      s = !rst && refHazard() && !f;
      chk("model_freeze_all", 32'(freeze_all), 32'(f));
      chk("model_stall_if_id", 32'(stall_if_id), 32'(s));
      chk("model_bubble_exe", 32'(bubble_exe), 32'(s));
      chk("model_mem_error", 32'(mem_error), 32'(mErr));
      chk("model_stall_cnt", 32'(stall_cnt), 32'(mStall));
      chk("model_freeze_cnt", 32'(freeze_cnt), 32'(mFreeze));
   endtask

   task automatic tick();
      bit f, s;
      f = refFreeze();
      s = !rst && refHazard() && !f;
      if (rst) begin
         modelReset();
      end else begin
         if (s && mStall < MAXC) mStall++;
         if (f && mFreeze < MAXC) mFreeze++;
         if (!mInWait) begin
            if (mem_start && !sram_ready) begin
               mInWait = 1; mWaited = 0;
            end
         end else if (sram_ready) begin
            mInWait = 0;
         end else if (mWaited == MT - 1) begin
            mInWait = 0; mErr = 1;
         end else begin
            mWaited++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run1();
      sampleCheck();
      tick();
   endtask

   task automatic doReset();
      rst = 1'b1; mem_start = 1'b0; sram_ready = 1'b0;
      run1();
      rst = 1'b0;
   endtask

   vec_t tbl[12];
   int   cnt;

   initial begin
      rst = 1'b1; mem_start = 1'b0; sram_ready = 1'b0;
      clearHazardInputs();
      @(posedge clk); @(posedge clk); #1;
      modelReset();

      // reset state, with a hazard present on the inputs
      setVec(mk(0, 5, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0));
      mem_start = 1'b1;
      sampleCheck();
      chk("rst_stall", 32'(stall_if_id), 32'd0);
      chk("rst_freeze", 32'(freeze_all), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();
      mem_start = 1'b0;
      rst = 1'b0;

      tbl[0]  = mk(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1);  // load-use on src1
      tbl[1]  = mk(1, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0);  // ALU producer, forwarded
      tbl[2]  = mk(0, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 1);  // same, no forwarding
      tbl[3]  = mk(0, 1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0);  // src2 replaced by immediate
      tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);  // R0 never hazards
      tbl[5]  = mk(0, 1, 5, 1, 1, 0, 5, 1, 0, 0, 0, 1);  // store reads src2
      tbl[6]  = mk(0, 1, 5, 1, 0, 2, 5, 1, 0, 0, 0, 1);  // BNE reads src2
      tbl[7]  = mk(0, 5, 7, 1, 0, 3, 5, 1, 0, 0, 0, 0);  // JMP ignores src1
      tbl[8]  = mk(0, 9, 2, 1, 0, 0, 3, 1, 0, 9, 1, 1);  // MEM producer, no forwarding
      tbl[9]  = mk(1, 9, 2, 1, 0, 0, 3, 1, 0, 9, 1, 0);  // MEM producer, forwarded
      tbl[10] = mk(0, 5, 2, 1, 0, 0, 5, 0, 0, 0, 0, 0);  // producer without WB
      tbl[11] = mk(1, 5, 2, 1, 0, 0, 5, 0, 1, 0, 0, 0);  // load without WB

      for (int i = 0; i < 12; i++) begin
         setVec(tbl[i]);
         sampleCheck();
         chk($sformatf("vec%0d_stall", i), 32'(stall_if_id), 32'(tbl[i].expStall));
         chk($sformatf("vec%0d_bubble", i), 32'(bubble_exe), 32'(tbl[i].expStall));
         tick();
      end

      // load-use stall lasts one cycle once the load advances to MEM
      clearHazardInputs();
      doReset();
      setVec(mk(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1));
      sampleCheck();
      chk("lu_stall_c0", 32'(stall_if_id), 32'd1);
      tick();
      setVec(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0));
      sampleCheck();
      chk("lu_stall_c1", 32'(stall_if_id), 32'd0);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      tick();

      // freeze for three cycles with a concurrent load-use hazard
      doReset();
      setVec(mk(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1));
      for (int i = 0; i < 3; i++) begin
         mem_start = (i == 0); sram_ready = 1'b0;
         sampleCheck();
         chk($sformatf("frz_c%0d", i), 32'(freeze_all), 32'd1);
         chk($sformatf("frz_bubble_c%0d", i), 32'(bubble_exe), 32'd0);
         tick();
      end
      mem_start = 1'b0; sram_ready = 1'b1;
      clearHazardInputs();
      sampleCheck();
      chk("frz_ready_cycle", 32'(freeze_all), 32'd0);
      tick();
      sram_ready = 1'b0;
      sampleCheck();
      chk("frz_cnt", 32'(freeze_cnt), 32'd3);
      chk("frz_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();

      // timeout: start cycle plus MT wait cycles, then sticky error
      doReset();
      mem_start = 1'b1; sram_ready = 1'b0;
      run1();
      mem_start = 1'b0;
      cnt = 0;
      while (mem_error !== 1'b1 && cnt < 40) begin
         run1();
         cnt++;
      end
      chk("tmo_wait_cycles", 32'(cnt), 32'(MT));
      sampleCheck();
      chk("tmo_freeze_released", 32'(freeze_all), 32'd0);
      chk("tmo_freeze_cnt", 32'(freeze_cnt), 32'(MT + 1));
      tick();
      for (int i = 0; i < 3; i++) run1();
      mem_start = 1'b1; sram_ready = 1'b1;
      run1();
      mem_start = 1'b0; sram_ready = 1'b0;
      sampleCheck();
      chk("tmo_error_sticky", 32'(mem_error), 32'd1);
      tick();

      // reset in the middle of a wait
      mem_start = 1'b1;
      run1();
      mem_start = 1'b0;
      run1(); run1();
      rst = 1'b1;
      sampleCheck();
      chk("rstwait_freeze_in_rst", 32'(freeze_all), 32'd0);
      tick();
      rst = 1'b0;
      sampleCheck();
      chk("rstwait_freeze", 32'(freeze_all), 32'd0);
      chk("rstwait_error", 32'(mem_error), 32'd0);
      chk("rstwait_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rstwait_freeze_cnt", 32'(freeze_cnt), 32'd0);
      tick();

      // ready arrives in the last timeout cycle
      mem_start = 1'b1;
      run1();
      mem_start = 1'b0;
      for (int i = 0; i < MT - 1; i++) run1();
      sram_ready = 1'b1;
      sampleCheck();
      chk("lastready_freeze", 32'(freeze_all), 32'd0);
      tick();
      sram_ready = 1'b0;
      sampleCheck();
      chk("lastready_no_error", 32'(mem_error), 32'd0);
      chk("lastready_freeze_cnt", 32'(freeze_cnt), 32'(MT));
      tick();

      // stall counter saturation
      doReset();
      setVec(mk(0, 5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 1));
      for (int i = 0; i < MAXC + 6; i++) run1();
      sampleCheck();
      chk("sat_stall_cnt", 32'(stall_cnt), 32'(MAXC));
      tick();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst          = ($urandom_range(0, 99) == 0);
         forward_en   = 1'($urandom_range(0, 1));
         ID_src1      = 5'($urandom_range(0, 6));
         ID_src2      = 5'($urandom_range(0, 6));
         ID_Is_Imm    = 1'($urandom_range(0, 1));
         ID_MEM_W_En  = 1'($urandom_range(0, 1));
         ID_BR_Type   = 2'($urandom_range(0, 3));
         EXE_dest     = 5'($urandom_range(0, 6));
         EXE_WB_En    = 1'($urandom_range(0, 1));
         EXE_MEM_R_En = 1'($urandom_range(0, 1));
         MEM_dest     = 5'($urandom_range(0, 6));
         MEM_WB_En    = 1'($urandom_range(0, 1));
         mem_start    = ($urandom_range(0, 7) == 0);
         sram_ready   = ($urandom_range(0, 6) == 0);
         run1();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
